// File: rtl/bfp_exp_align_stream.sv
// Block floating-point exponent alignment: collects up to BEATS beats of LANES exponents,
// finds the block maximum, then replays the block as per-lane shifts (max - exp).
module bfp_exp_align_stream #(
    parameter int LANES     = 16,
    parameter int BEATS     = 8,
    parameter int EXP_WIDTH = 4,
    parameter int SHIFT_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_sat_en,
    input  logic                       cfg_zero_skip,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*EXP_WIDTH-1:0] in_exp,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*EXP_WIDTH-1:0] out_shift,
    output logic [EXP_WIDTH-1:0]       out_exp_max,
    output logic                       out_last
);

    localparam int AW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(BEATS + 1);
    localparam int EW = EXP_WIDTH;
    localparam int DW = LANES * EXP_WIDTH;
    localparam logic [EW-1:0] SMAX = EW'(SHIFT_MAX);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          run;
    logic [CW-1:0] wr_cnt, rd_cnt, n_beats;
    logic [EW-1:0] max_reg;
    logic          sat_q, skip_q;
    logic [DW-1:0] buf_mem [BEATS];

    logic          in_fire, out_fire, close_blk, first_beat, skip_eff;
    logic [EW-1:0] beat_max;
    logic [DW-1:0] rd_row, shift_raw;
    logic [EW-1:0] bm_e;
    logic [EW-1:0] sh_e, sh_d;

    // run holds in_ready low through the reset cycle without a combinational rst_n path
    assign in_ready   = run && (state == COLLECT);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = (state == DRAIN);
    assign out_last   = out_valid && (rd_cnt == n_beats - CW'(1));
    assign out_fire   = out_valid && out_ready;
    assign first_beat = (wr_cnt == '0);
    assign skip_eff   = first_beat ? cfg_zero_skip : skip_q;
    assign close_blk  = in_fire && (in_last || (wr_cnt == CW'(BEATS - 1)));

    always_comb begin
        beat_max = '0;
        bm_e     = '0;
        for (int i = 0; i < LANES; i++) begin
            bm_e = in_exp[i*EW +: EW];
            if (!(skip_eff && (bm_e == '0)) && (bm_e > beat_max))
                beat_max = bm_e;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close_blk) state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run     <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            n_beats <= '0;
            max_reg <= '0;
            sat_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (in_fire) begin
                wr_cnt <= wr_cnt + CW'(1);
                if (first_beat) begin
                    sat_q   <= cfg_sat_en;
                    skip_q  <= cfg_zero_skip;
                    max_reg <= beat_max;
                end else if (beat_max > max_reg) begin
                    max_reg <= beat_max;
                end
                if (close_blk) n_beats <= wr_cnt + CW'(1);
            end
            if (out_fire) begin
                if (out_last) begin
                    wr_cnt  <= '0;
                    rd_cnt  <= '0;
                    n_beats <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) buf_mem[wr_cnt[AW-1:0]] <= in_exp;
    end

    assign rd_row = buf_mem[rd_cnt[AW-1:0]];

    // max_reg >= every stored non-skipped exponent, so the subtraction never wraps
    always_comb begin
        shift_raw = '0;
        sh_e      = '0;
        sh_d      = '0;
        for (int i = 0; i < LANES; i++) begin
            sh_e = rd_row[i*EW +: EW];
            sh_d = max_reg - sh_e;
            if (skip_q && (sh_e == '0))
                shift_raw[i*EW +: EW] = SMAX;
            else if (sat_q && (sh_d > SMAX))
                shift_raw[i*EW +: EW] = SMAX;
            else
                shift_raw[i*EW +: EW] = sh_d;
        end
    end

    assign out_shift   = out_valid ? shift_raw : '0;
    assign out_exp_max = out_valid ? max_reg : '0;

endmodule
